// File: rtl/uart_pkg.sv
// Shared UART definitions: the default data width, the default FIFO depths for
// the Tx and Rx paths, and a helper that sizes a FIFO occupancy counter.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_TX_FIFO_DEPTH = 16;
  localparam int UART_RX_FIFO_DEPTH = 16;

  // An occupancy counter must reach DEPTH itself, so it needs one bit more than the pointers.
  function automatic int fifo_count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART FIFO. It has one synchronous write port and one
// asynchronous read port. The contents have no reset.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store wdata at waddr on accepted pushes
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: the addressed word is always visible combinationally
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/uart_fifo_gen2.sv
// Parametrised synchronous FIFO used between the APB register block and the
// UART shifters. It provides an occupancy count, almost-full and almost-empty
// flags, overflow and underflow pulses, and a synchronous flush.
// Build option UART_FIFO_FWFT_EN selects first-word-fall-through reads.
// Without it, pop_data is registered and has one cycle of latency.
module uart_fifo_gen2
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = UART_TX_FIFO_DEPTH,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              push_ok;
  logic              pop_ok;
  logic              mem_we;
  logic [DATA_W-1:0] rd_data;

  // Accept decisions use the current count. When the FIFO is full, a push is
  // still accepted if a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != FULL_CNT) || pop);
    mem_we  = push_ok && !clr;
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (push_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointer, count and error-pulse state. A flush overrides any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      overflow_q  <= push && !push_ok;
      underflow_q <= pop && !pop_ok;
    end
  end

`ifdef UART_FIFO_FWFT_EN
  // Head of the FIFO is presented directly; zero while nothing is stored
  always_comb begin
    pop_data = (count_q == '0) ? '0 : rd_data;
  end
`else
  logic [DATA_W-1:0] pop_data_q;

  // Registered read: capture the head word on an accepted pop, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_data_q <= '0;
    end else if (clr) begin
      pop_data_q <= '0;
    end else if (pop_ok) begin
      pop_data_q <= rd_data;
    end
  end

  // Drive the read port from the capture register
  always_comb begin
    pop_data = pop_data_q;
  end
`endif

  // Status outputs are decoded combinationally from the count register
  always_comb begin
    count        = count_q;
    empty        = (count_q == '0);
    full         = (count_q == FULL_CNT);
    almost_full  = (count_q >= AF_CNT);
    almost_empty = (count_q <= AE_CNT);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_uart_fifo_gen2.sv
// Directed bench for uart_fifo_gen2 with its default parameters (8-bit, 16 deep).
// A queue model of the FIFO contents supplies every expected value.
module tb_uart_fifo_gen2;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_pd;
  bit         exp_ovf;
  bit         exp_udf;

  uart_fifo_gen2 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_data     (pop_data),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [7:0] pd;
    n = mq.size();
`ifdef UART_FIFO_FWFT_EN
    pd = (n > 0) ? mq[0] : 8'h00;
`else
    pd = exp_pd;
`endif
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == 16));
    check({tag, ".almost_full"}, 32'(almost_full), 32'(n >= 14));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= 2));
    check({tag, ".pop_data"}, 32'(pop_data), 32'(pd));
    check({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
  endtask

  // One clock cycle with the given inputs; the model is updated from the state before the edge
  task automatic step(input string tag, input bit p, input logic [7:0] d, input bit r, input bit c);
    int n;
    bit pa;
    bit ra;
    logic [7:0] v;
    @(negedge clk);
    push = p; push_data = d; pop = r; clr = c;
    n  = mq.size();
    pa = p && ((n < 16) || r);
    ra = r && (n > 0);
    if (c) begin
      mq.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      exp_pd  = 8'h00;
    end else begin
      if (ra) begin
        v = mq.pop_front();
        exp_pd = v;
      end
      if (pa) mq.push_back(d);
      exp_ovf = p && !pa;
      exp_udf = r && !ra;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; push = 1'b0; pop = 1'b0; push_data = 8'h00;
    exp_pd = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle0", 0, 8'h00, 0, 0);
    step("idle1", 0, 8'h00, 0, 0);

    // Fill to full, then one rejected push
    for (int i = 0; i < 16; i++) step("fill", 1, 8'(i), 0, 0);
    step("ovf", 1, 8'hAA, 0, 0);
    step("ovf_clear", 0, 8'h00, 0, 0);
    for (int i = 0; i < 16; i++) step("drain", 0, 8'h00, 1, 0);

    // Underflow cases on an empty FIFO
    step("udf", 0, 8'h00, 1, 0);
    step("udf_clear", 0, 8'h00, 0, 0);
    step("empty_pushpop", 1, 8'h55, 1, 0);
    step("pop55", 0, 8'h00, 1, 0);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 16; i++) step("refill", 1, 8'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 40; i++) step("full_pushpop", 1, 8'($urandom_range(0, 255)), 1, 0);
    for (int i = 0; i < 16; i++) step("drain2", 0, 8'h00, 1, 0);

    // Flush with a push in the same cycle
    for (int i = 0; i < 9; i++) step("fill9", 1, 8'(8'h90 + i), 0, 0);
    step("clr_push", 1, 8'hEE, 0, 1);
    step("after_clr", 0, 8'h00, 0, 0);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 5; i++) step("burst", 1, 8'(8'hC0 + i), (i > 2), 0);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete(); exp_pd = 8'h00; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    step("post_rst_push", 1, 8'h3C, 0, 0);
    step("post_rst_push2", 1, 8'h3D, 0, 0);
    step("post_rst_pop", 0, 8'h00, 1, 0);
    step("post_rst_pop2", 0, 8'h00, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
